// File: rtl/axis_fifo_arbiter.sv
// Two-port AXI-Stream to FIFO arbiter: packet-atomic round-robin grant,
// one arbitration cycle per packet, per-port completed-packet counters.
module axis_fifo_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s0_tdata,
  input  logic             s0_tvalid,
  input  logic             s0_tlast,
  output logic             s0_tready,
  input  logic [WIDTH-1:0] s1_tdata,
  input  logic             s1_tvalid,
  input  logic             s1_tlast,
  output logic             s1_tready,
  output logic             fifo_wr_en,
  output logic [WIDTH-1:0] fifo_din,
  output logic             fifo_din_last,
  input  logic             fifo_full,
  output logic [1:0]       grant,
  output logic [7:0]       pkt_cnt0,
  output logic [7:0]       pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY0 = 2'b01,
    BUSY1 = 2'b10
  } state_t;

  state_t     state_r, state_s;
  logic       last_served_r, last_served_s;
  logic [1:0] grant_r, grant_s;
  logic [7:0] pkt_cnt0_r, pkt_cnt0_s;
  logic [7:0] pkt_cnt1_r, pkt_cnt1_s;
  logic       xfer0_s, xfer1_s;

  // State, round-robin history, registered grant and packet counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      last_served_r <= 1'b1;
      grant_r       <= 2'b00;
      pkt_cnt0_r    <= 8'd0;
      pkt_cnt1_r    <= 8'd0;
    end else begin
      state_r       <= state_s;
      last_served_r <= last_served_s;
      grant_r       <= grant_s;
      pkt_cnt0_r    <= pkt_cnt0_s;
      pkt_cnt1_r    <= pkt_cnt1_s;
    end
  end

  // Next-state, handshakes and FIFO write mux
  always_comb begin
    state_s       = state_r;
    last_served_s = last_served_r;
    pkt_cnt0_s    = pkt_cnt0_r;
    pkt_cnt1_s    = pkt_cnt1_r;
    s0_tready     = 1'b0;
    s1_tready     = 1'b0;
    xfer0_s       = 1'b0;
    xfer1_s       = 1'b0;
    fifo_wr_en    = 1'b0;
    fifo_din      = {WIDTH{1'b0}};
    fifo_din_last = 1'b0;
    grant_s       = 2'b00;
    case (state_r)
      IDLE: begin
        // On a tie, the port that did not finish the previous packet wins
        if (s0_tvalid && s1_tvalid) begin
          state_s = last_served_r ? BUSY0 : BUSY1;
        end else if (s0_tvalid) begin
          state_s = BUSY0;
        end else if (s1_tvalid) begin
          state_s = BUSY1;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY0: begin
        s0_tready     = !fifo_full;
        xfer0_s       = s0_tvalid && !fifo_full;
        fifo_wr_en    = xfer0_s;
        fifo_din      = s0_tdata;
        fifo_din_last = s0_tlast;
        if (xfer0_s && s0_tlast) begin
          state_s       = IDLE;
          last_served_s = 1'b0;
          pkt_cnt0_s    = pkt_cnt0_r + 8'd1;
        end else begin
          state_s = BUSY0;
        end
      end
      BUSY1: begin
        s1_tready     = !fifo_full;
        xfer1_s       = s1_tvalid && !fifo_full;
        fifo_wr_en    = xfer1_s;
        fifo_din      = s1_tdata;
        fifo_din_last = s1_tlast;
        if (xfer1_s && s1_tlast) begin
          state_s       = IDLE;
          last_served_s = 1'b1;
          pkt_cnt1_s    = pkt_cnt1_r + 8'd1;
        end else begin
          state_s = BUSY1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    case (state_s)
      BUSY0:   grant_s = 2'b01;
      BUSY1:   grant_s = 2'b10;
      default: grant_s = 2'b00;
    endcase
  end

  assign grant    = grant_r;
  assign pkt_cnt0 = pkt_cnt0_r;
  assign pkt_cnt1 = pkt_cnt1_r;

endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// Self-checking bench for axis_fifo_arbiter: directed scenarios plus
// randomized packet traffic checked against a packet-level round-robin model.
module tb_axis_fifo_arbiter;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] s0_tdata, s1_tdata;
  logic         s0_tvalid, s0_tlast, s0_tready;
  logic         s1_tvalid, s1_tlast, s1_tready;
  logic         fifo_wr_en, fifo_din_last, fifo_full;
  logic [W-1:0] fifo_din;
  logic [1:0]   grant;
  logic [7:0]   pkt_cnt0, pkt_cnt1;

  // Source beats {last,data}; recorded and expected writes {port,last,data}
  logic [W:0]   src0_q[$], src1_q[$];
  logic [W+1:0] got_q[$], exp_q[$];
  int           got_cyc_q[$];
  int           viol, exp_pk0, exp_pk1;
  bit           eng_timeout;
  int           n_cmp, n_err;

  axis_fifo_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_din_last(fifo_din_last),
    .fifo_full(fifo_full), .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task apply_reset;
    rst = 1'b1;
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; fifo_full = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task add_packet(input int port, input int len);
    logic [W:0] b;
    for (int i = 0; i < len; i++) begin
      b = {(i == len - 1), W'($urandom)};
      if (port == 0) src0_q.push_back(b);
      else src1_q.push_back(b);
    end
  endtask

  // Packet-level model: whole packets, alternating ports while both have work,
  // port 0 first after reset
  task build_expected;
    logic [W:0] m0[$], m1[$];
    logic [W:0] b;
    int p, nxt;
    bit done;
    m0 = src0_q; m1 = src1_q;
    exp_q.delete(); exp_pk0 = 0; exp_pk1 = 0; nxt = 0;
    while (m0.size() != 0 || m1.size() != 0) begin
      if (m0.size() != 0 && m1.size() != 0) p = nxt;
      else if (m0.size() != 0) p = 0;
      else p = 1;
      done = 1'b0;
      while (!done && ((p == 0) ? m0.size() : m1.size()) != 0) begin
        b = (p == 0) ? m0.pop_front() : m1.pop_front();
        exp_q.push_back({p[0], b});
        done = b[W];
      end
      if (p == 0) exp_pk0++;
      else exp_pk1++;
      nxt = 1 - p;
    end
  endtask

  // Drives the queued beats (first beat of a packet never gapped) and records writes
  task run_engine(input int max_cycles, input int gap_pct, input int full_pct);
    logic mid0, mid1, acc0, acc1;
    int c;
    got_q.delete(); got_cyc_q.delete();
    viol = 0; mid0 = 1'b0; mid1 = 1'b0; c = 0;
    while ((src0_q.size() != 0 || src1_q.size() != 0) && c < max_cycles) begin
      if (src0_q.size() != 0 && !(mid0 && $urandom_range(0, 99) < gap_pct)) begin
        s0_tvalid = 1'b1; {s0_tlast, s0_tdata} = src0_q[0];
      end else begin
        s0_tvalid = 1'b0; s0_tdata = W'($urandom); s0_tlast = 1'($urandom);
      end
      if (src1_q.size() != 0 && !(mid1 && $urandom_range(0, 99) < gap_pct)) begin
        s1_tvalid = 1'b1; {s1_tlast, s1_tdata} = src1_q[0];
      end else begin
        s1_tvalid = 1'b0; s1_tdata = W'($urandom); s1_tlast = 1'($urandom);
      end
      fifo_full = ($urandom_range(0, 99) < full_pct);
      @(negedge clk);
      if (fifo_wr_en) begin
        got_q.push_back({grant[1], fifo_din_last, fifo_din});
        got_cyc_q.push_back(c);
        if (fifo_full) viol++;
      end
      if ((s0_tready && grant != 2'b01) || (s1_tready && grant != 2'b10) ||
          (fifo_full && (s0_tready || s1_tready))) viol++;
      acc0 = s0_tvalid & s0_tready;
      acc1 = s1_tvalid & s1_tready;
      tick;
      if (acc0) begin mid0 = !src0_q[0][W]; void'(src0_q.pop_front()); end
      if (acc1) begin mid1 = !src1_q[0][W]; void'(src1_q.pop_front()); end
      c++;
    end
    eng_timeout = (src0_q.size() != 0 || src1_q.size() != 0);
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; fifo_full = 1'b0;
    @(negedge clk);
  endtask

  task test_reset;
    rst = 1'b1; fifo_full = 1'b0;
    s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 8'hA5;
    s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tdata = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({grant, s0_tready, s1_tready, fifo_wr_en, fifo_din_last} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 000000", {grant, s0_tready, s1_tready, fifo_wr_en, fifo_din_last});
    end
    n_cmp++;
    if (fifo_din !== 8'h00) begin n_err++; $display("FAIL reset_din: got %h want 00", fifo_din); end
    n_cmp++;
    if ({pkt_cnt0, pkt_cnt1} !== 16'h0000) begin
      n_err++; $display("FAIL reset_cnt: got %h/%h want 00/00", pkt_cnt0, pkt_cnt1);
    end
    @(posedge clk); #1;
    rst = 1'b0; s0_tvalid = 1'b0; s1_tvalid = 1'b0;
  endtask

  task test_single_port;
    logic [W-1:0] a[3];
    for (int i = 0; i < 3; i++) a[i] = W'($urandom);
    s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tdata = a[0];
    @(negedge clk);
    n_cmp++;
    if ({grant, s0_tready, fifo_wr_en} !== 4'b0000) begin
      n_err++; $display("FAIL single_arb_cycle: got %b want 0000", {grant, s0_tready, fifo_wr_en});
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      s0_tdata = a[i]; s0_tlast = (i == 2);
      @(negedge clk);
      n_cmp++;
      if ({grant, fifo_wr_en, fifo_din_last, fifo_din} !== {2'b01, 1'b1, (i == 2), a[i]}) begin
        n_err++; $display("FAIL single_beat%0d: got %b/%b/%b/%h want 01/1/%b/%h",
                          i, grant, fifo_wr_en, fifo_din_last, fifo_din, (i == 2), a[i]);
      end
    end
    tick;
    s0_tvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({grant, fifo_wr_en, pkt_cnt0} !== {2'b00, 1'b0, 8'd1}) begin
      n_err++; $display("FAIL single_done: got grant %b wr %b cnt0 %0d want 00 0 1", grant, fifo_wr_en, pkt_cnt0);
    end
  endtask

  task test_tie;
    apply_reset;
    add_packet(0, 2);
    add_packet(1, 2);
    build_expected;
    run_engine(100, 0, 0);
    n_cmp++;
    if (got_q.size() != exp_q.size() || eng_timeout) begin
      n_err++; $display("FAIL tie_len: got %0d writes (timeout %0d) want %0d", got_q.size(), eng_timeout, exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL tie_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    if (got_cyc_q.size() >= 3) begin
      n_cmp++;
      if (got_cyc_q[1] - got_cyc_q[0] != 1 || got_cyc_q[2] - got_cyc_q[1] != 2) begin
        n_err++; $display("FAIL tie_timing: got write cycles %0d,%0d,%0d want n,n+1,n+3",
                          got_cyc_q[0], got_cyc_q[1], got_cyc_q[2]);
      end
    end
    n_cmp++;
    if ({pkt_cnt0, pkt_cnt1, grant} !== {8'd1, 8'd1, 2'b00}) begin
      n_err++; $display("FAIL tie_cnt: got %0d/%0d grant %b want 1/1 00", pkt_cnt0, pkt_cnt1, grant);
    end
  endtask

  task test_full_stall;
    logic [W-1:0] b[3];
    apply_reset;
    for (int i = 0; i < 3; i++) b[i] = W'($urandom);
    s1_tvalid = 1'b1; s1_tlast = 1'b0; s1_tdata = b[0];
    @(negedge clk);
    n_cmp++;
    if ({grant, s1_tready} !== 3'b000) begin n_err++; $display("FAIL full_arb: got %b want 000", {grant, s1_tready}); end
    tick;
    @(negedge clk);
    n_cmp++;
    if ({grant, s1_tready, fifo_wr_en, fifo_din} !== {2'b10, 1'b1, 1'b1, b[0]}) begin
      n_err++; $display("FAIL full_beat0: got %b/%b/%b/%h want 10/1/1/%h", grant, s1_tready, fifo_wr_en, fifo_din, b[0]);
    end
    tick;
    s1_tdata = b[1]; fifo_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({grant, s1_tready, fifo_wr_en} !== 4'b1000) begin
        n_err++; $display("FAIL full_stall%0d: got %b want 1000", k, {grant, s1_tready, fifo_wr_en});
      end
      tick;
      if (k == 3) fifo_full = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if ({fifo_wr_en, fifo_din_last, fifo_din} !== {2'b10, b[1]}) begin
      n_err++; $display("FAIL full_beat1: got %b/%b/%h want 1/0/%h", fifo_wr_en, fifo_din_last, fifo_din, b[1]);
    end
    tick;
    s1_tdata = b[2]; s1_tlast = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({fifo_wr_en, fifo_din_last, fifo_din} !== {2'b11, b[2]}) begin
      n_err++; $display("FAIL full_beat2: got %b/%b/%h want 1/1/%h", fifo_wr_en, fifo_din_last, fifo_din, b[2]);
    end
    tick;
    s1_tvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({grant, pkt_cnt1} !== {2'b00, 8'd1}) begin
      n_err++; $display("FAIL full_done: got grant %b cnt1 %0d want 00 1", grant, pkt_cnt1);
    end
  endtask

  task test_nongranted;
    apply_reset;
    add_packet(0, 3);
    add_packet(0, 3);
    add_packet(1, 2);
    build_expected;
    run_engine(200, 0, 0);
    n_cmp++;
    if (got_q.size() != exp_q.size() || eng_timeout) begin
      n_err++; $display("FAIL rr_len: got %0d writes (timeout %0d) want %0d", got_q.size(), eng_timeout, exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rr_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++;
    if ({pkt_cnt0, pkt_cnt1, viol} !== {8'd2, 8'd1, 32'd0}) begin
      n_err++; $display("FAIL rr_cnt: got %0d/%0d viol %0d want 2/1 0", pkt_cnt0, pkt_cnt1, viol);
    end
  endtask

  task test_reset_mid;
    logic [W-1:0] d;
    d = W'($urandom);
    tick;
    s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tdata = 8'hC1;
    tick;
    @(negedge clk);
    tick;
    s0_tdata = 8'hC2;
    @(negedge clk);
    n_cmp++;
    if ({grant, fifo_wr_en, fifo_din} !== {2'b01, 1'b1, 8'hC2}) begin
      n_err++; $display("FAIL rstmid_beat2: got %b/%b/%h want 01/1/c2", grant, fifo_wr_en, fifo_din);
    end
    tick;
    s0_tdata = 8'hC3; rst = 1'b1;
    #1;
    n_cmp++;
    if ({grant, s0_tready, s1_tready, fifo_wr_en, fifo_din_last, fifo_din} !== {6'b0, 8'h00}) begin
      n_err++; $display("FAIL rstmid_outputs: got %b/%b/%b/%b/%b/%h want all zero",
                        grant, s0_tready, s1_tready, fifo_wr_en, fifo_din_last, fifo_din);
    end
    n_cmp++;
    if ({pkt_cnt0, pkt_cnt1} !== 16'h0000) begin
      n_err++; $display("FAIL rstmid_cnt: got %0d/%0d want 0/0", pkt_cnt0, pkt_cnt1);
    end
    tick;
    tick;
    rst = 1'b0; s0_tdata = d; s0_tlast = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({grant, fifo_wr_en} !== 3'b000) begin n_err++; $display("FAIL rstmid_arb: got %b want 000", {grant, fifo_wr_en}); end
    tick;
    @(negedge clk);
    n_cmp++;
    if ({grant, fifo_wr_en, fifo_din_last, fifo_din} !== {2'b01, 2'b11, d}) begin
      n_err++; $display("FAIL rstmid_new: got %b/%b/%b/%h want 01/1/1/%h", grant, fifo_wr_en, fifo_din_last, fifo_din, d);
    end
    tick;
    s0_tvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({grant, pkt_cnt0} !== {2'b00, 8'd1}) begin
      n_err++; $display("FAIL rstmid_done: got grant %b cnt0 %0d want 00 1", grant, pkt_cnt0);
    end
  endtask

  task test_wrap;
    int nlast;
    apply_reset;
    for (int i = 0; i < 256; i++) add_packet(0, 1);
    build_expected;
    run_engine(2000, 0, 0);
    nlast = 0;
    foreach (got_q[i]) if (got_q[i][W]) nlast++;
    n_cmp++;
    if (got_q.size() != 256 || nlast != 256 || eng_timeout) begin
      n_err++; $display("FAIL wrap_writes: got %0d writes %0d last want 256 256", got_q.size(), nlast);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++;
    if (pkt_cnt0 !== 8'(exp_pk0)) begin n_err++; $display("FAIL wrap_cnt0: got %0d want %0d", pkt_cnt0, 8'(exp_pk0)); end
  endtask

  task test_random;
    for (int it = 0; it < 3; it++) begin
      apply_reset;
      for (int p = 0; p < $urandom_range(5, 15); p++) add_packet(0, $urandom_range(1, 6));
      for (int p = 0; p < $urandom_range(5, 15); p++) add_packet(1, $urandom_range(1, 6));
      build_expected;
      run_engine(5000, 25, 30);
      n_cmp++;
      if (got_q.size() != exp_q.size() || eng_timeout) begin
        n_err++; $display("FAIL rand%0d_len: got %0d writes (timeout %0d) want %0d", it, got_q.size(), eng_timeout, exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_beat%0d: got %h want %h", it, i, got_q[i], exp_q[i]); end
      end
      n_cmp++;
      if (pkt_cnt0 !== 8'(exp_pk0) || pkt_cnt1 !== 8'(exp_pk1) || viol != 0) begin
        n_err++; $display("FAIL rand%0d_cnt: got %0d/%0d viol %0d want %0d/%0d 0", it, pkt_cnt0, pkt_cnt1, viol, exp_pk0, exp_pk1);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; fifo_full = 1'b0;
    s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tdata = '0;
    s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = '0;
    test_reset;
    test_single_port;
    test_tie;
    test_full_stall;
    test_nongranted;
    test_reset_mid;
    test_wrap;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
